// File: rtl/ulpb_rx_msg_fifo.sv
// Receive buffer behind a ulpb node RX port: completes the four-phase handshake and releases only committed messages.
// Optional build macro ULPB_RX_FIFO_DROP_CNT_EN enables the saturating dropped-message counter on DROP_CNT.
module ulpb_rx_msg_fifo #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned PTR_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [ADDR_WIDTH-1:0] RX_ADDR,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_PEND,
    input  logic                  RX_REQ,
    input  logic                  RX_FAIL,
    output logic                  RX_ACK,
    output logic [ADDR_WIDTH-1:0] MSG_ADDR,
    output logic [DATA_WIDTH-1:0] MSG_DATA,
    output logic                  MSG_LAST,
    output logic                  MSG_VALID,
    input  logic                  MSG_READY,
    output logic                  OVERFLOW,
    output logic [7:0]            DROP_CNT
);

    typedef logic [PTR_WIDTH:0] ptr_t;
    typedef enum logic [1:0] {IDLE, ACK, FAIL_ACK} state_t;

    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t DEPTH_CNT = ptr_t'(DEPTH);

    state_t state, state_nxt;
    logic [1:0] req_sync, fail_sync;
    logic req_s, fail_s;
    ptr_t rd_ptr, wr_ptr, commit_ptr;
    ptr_t wr_nxt, commit_nxt;
    ptr_t used, avail;
    logic discard, discard_nxt;
    logic we, ovf_set, pop, full;

    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic                  last_mem [DEPTH];

    assign req_s  = req_sync[1];
    assign fail_s = fail_sync[1];
    assign used   = wr_ptr - rd_ptr;
    assign avail  = commit_ptr - rd_ptr;
    assign full   = (used == DEPTH_CNT);

    assign MSG_VALID = (avail != '0);
    assign pop       = MSG_VALID && MSG_READY;
    assign MSG_ADDR  = MSG_VALID ? addr_mem[rd_ptr[PTR_WIDTH-1:0]] : '0;
    assign MSG_DATA  = MSG_VALID ? data_mem[rd_ptr[PTR_WIDTH-1:0]] : '0;
    assign MSG_LAST  = MSG_VALID ? last_mem[rd_ptr[PTR_WIDTH-1:0]] : 1'b0;

    // Two-flop synchronizers for the node's asynchronous request lines
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            req_sync  <= '0;
            fail_sync <= '0;
        end else begin
            req_sync  <= {req_sync[0], RX_REQ};
            fail_sync <= {fail_sync[0], RX_FAIL};
        end
    end

    always_comb begin
        state_nxt   = state;
        wr_nxt      = wr_ptr;
        commit_nxt  = commit_ptr;
        discard_nxt = discard;
        we          = 1'b0;
        ovf_set     = 1'b0;
        case (state)
            IDLE: begin
                if (fail_s) begin
                    wr_nxt      = commit_ptr;
                    discard_nxt = 1'b0;
                    state_nxt   = FAIL_ACK;
                end else if (req_s) begin
                    if (!discard) begin
                        if (!full) begin
                            we     = 1'b1;
                            wr_nxt = wr_ptr + PTR_ONE;
                        end else begin
                            // No room: roll back the partial message and swallow its remainder
                            wr_nxt      = commit_ptr;
                            discard_nxt = 1'b1;
                            ovf_set     = 1'b1;
                        end
                    end
                    if (!RX_PEND) begin
                        commit_nxt  = wr_nxt;
                        discard_nxt = 1'b0;
                    end
                    state_nxt = ACK;
                end
            end
            ACK:      if (!req_s)  state_nxt = IDLE;
            FAIL_ACK: if (!fail_s) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            discard    <= 1'b0;
            RX_ACK     <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_nxt;
            commit_ptr <= commit_nxt;
            discard    <= discard_nxt;
            RX_ACK     <= (state_nxt != IDLE);
            if (ovf_set) OVERFLOW <= 1'b1;
            if (pop)     rd_ptr   <= rd_ptr + PTR_ONE;
        end
    end

    // Word store; contents are don't-care outside the committed window
    always_ff @(posedge CLK) begin
        if (we) begin
            addr_mem[wr_ptr[PTR_WIDTH-1:0]] <= RX_ADDR;
            data_mem[wr_ptr[PTR_WIDTH-1:0]] <= RX_DATA;
            last_mem[wr_ptr[PTR_WIDTH-1:0]] <= ~RX_PEND;
        end
    end

`ifdef ULPB_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                             drop_cnt <= 8'h00;
        else if (ovf_set && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'h01;
    end
    assign DROP_CNT = drop_cnt;
`else
    assign DROP_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_ulpb_rx_msg_fifo.sv
// Scoreboard bench for ulpb_rx_msg_fifo: handshake latency, commit/rollback, overflow, streaming and reset.
module tb_ulpb_rx_msg_fifo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  RX_ADDR;
    logic [31:0] RX_DATA;
    logic        RX_PEND;
    logic        RX_REQ;
    logic        RX_FAIL;
    logic        RX_ACK;
    logic [7:0]  MSG_ADDR;
    logic [31:0] MSG_DATA;
    logic        MSG_LAST;
    logic        MSG_VALID;
    logic        MSG_READY;
    logic        OVERFLOW;
    logic [7:0]  DROP_CNT;

    int n_vec = 0;
    int n_err = 0;
    logic [40:0] sb [$];
    logic [40:0] stage [$];

    ulpb_rx_msg_fifo dut (
        .CLK(CLK), .RESET(RESET),
        .RX_ADDR(RX_ADDR), .RX_DATA(RX_DATA), .RX_PEND(RX_PEND),
        .RX_REQ(RX_REQ), .RX_FAIL(RX_FAIL), .RX_ACK(RX_ACK),
        .MSG_ADDR(MSG_ADDR), .MSG_DATA(MSG_DATA), .MSG_LAST(MSG_LAST),
        .MSG_VALID(MSG_VALID), .MSG_READY(MSG_READY),
        .OVERFLOW(OVERFLOW), .DROP_CNT(DROP_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Layer-side monitor: each accepted head word must match the oldest expected word
    always @(negedge CLK) begin
        if (MSG_VALID === 1'b1 && MSG_READY === 1'b1) begin
            if (sb.size() == 0) check_eq("pop_unexpected", 64'd1, 64'd0);
            else check_eq("pop_word", {23'd0, MSG_ADDR, MSG_DATA, MSG_LAST}, {23'd0, sb.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, output int edges);
        edges = 0;
        while (RX_ACK !== lvl && edges < 20) begin
            step();
            edges++;
        end
        check_eq("ack_level", {63'd0, RX_ACK}, {63'd0, lvl});
    endtask

    task automatic send_word(input logic [7:0] a, input logic [31:0] d, input logic pend);
        int e;
        RX_ADDR = a;
        RX_DATA = d;
        RX_PEND = pend;
        RX_REQ  = 1'b1;
        wait_ack(1'b1, e);
        RX_REQ = 1'b0;
        wait_ack(1'b0, e);
    endtask

    task automatic send_fail();
        int e;
        RX_FAIL = 1'b1;
        wait_ack(1'b1, e);
        RX_FAIL = 1'b0;
        wait_ack(1'b0, e);
    endtask

    // Random n-word message; words reach the scoreboard only if a commit is expected
    task automatic send_msg(input int n, input logic commit);
        logic [7:0]  a;
        logic [31:0] d;
        logic        pend;
        for (int i = 0; i < n; i++) begin
            a    = 8'($urandom);
            d    = $urandom;
            pend = (i != n - 1);
            stage.push_back({a, d, ~pend});
            if (!pend && commit) begin
                while (stage.size() != 0) sb.push_back(stage.pop_front());
            end
            send_word(a, d, pend);
        end
        stage.delete();
    endtask

    task automatic drain();
        int c = 0;
        MSG_READY = 1'b1;
        while ((sb.size() != 0 || MSG_VALID) && c < 200) begin
            step();
            c++;
        end
        check_eq("drain_left", 64'(sb.size()), 64'd0);
        check_eq("idle_head_zero", {23'd0, MSG_ADDR, MSG_DATA, MSG_LAST}, 64'd0);
    endtask

    initial begin
        int e;
        logic [40:0] w3 [3];
        RESET = 1'b1; RX_ADDR = '0; RX_DATA = '0; RX_PEND = 1'b0;
        RX_REQ = 1'b0; RX_FAIL = 1'b0; MSG_READY = 1'b0;
        step(); step();
        check_eq("rst_ack", {63'd0, RX_ACK}, 64'd0);
        check_eq("rst_valid", {63'd0, MSG_VALID}, 64'd0);
        check_eq("rst_head", {23'd0, MSG_ADDR, MSG_DATA, MSG_LAST}, 64'd0);
        check_eq("rst_ovf", {56'd0, DROP_CNT, 7'd0, OVERFLOW}, 64'd0);
        RESET = 1'b0;
        step();

        // Single word with exact handshake latency
        sb.push_back({8'hab, 32'hdeadbeef, 1'b1});
        RX_ADDR = 8'hab; RX_DATA = 32'hdeadbeef; RX_PEND = 1'b0; RX_REQ = 1'b1;
        wait_ack(1'b1, e);
        check_eq("ack_rise_lat", 64'(e), 64'd3);
        RX_REQ = 1'b0;
        wait_ack(1'b0, e);
        check_eq("ack_fall_lat", 64'(e), 64'd3);
        check_eq("single_valid", {63'd0, MSG_VALID}, 64'd1);
        check_eq("single_head", {23'd0, MSG_ADDR, MSG_DATA, MSG_LAST}, {23'd0, 8'hab, 32'hdeadbeef, 1'b1});
        MSG_READY = 1'b1;
        step();
        MSG_READY = 1'b0;
        check_eq("single_empty", {63'd0, MSG_VALID}, 64'd0);

        // Three-word message held back until the last word
        w3[0] = {8'h11, 32'h1000_0001, 1'b0};
        w3[1] = {8'h22, 32'h2000_0002, 1'b0};
        w3[2] = {8'h33, 32'h3000_0003, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if (i == 2) for (int k = 0; k < 3; k++) sb.push_back(w3[k]);
            send_word(w3[i][40:33], w3[i][32:1], ~w3[i][0]);
            check_eq($sformatf("three_valid_%0d", i), {63'd0, MSG_VALID}, {63'd0, (i == 2)});
        end
        drain();

        // Fail rollback of a partial message
        MSG_READY = 1'b0;
        send_word(8'h44, 32'h4444_4444, 1'b1);
        send_word(8'h55, 32'h5555_5555, 1'b1);
        send_fail();
        check_eq("fail_valid", {63'd0, MSG_VALID}, 64'd0);
        check_eq("fail_used", 64'(dut.used), 64'd0);
        send_msg(1, 1'b1);
        drain();

        // Overflow: ten words into an eight-entry store
        send_msg(10, 1'b0);
        step();
        check_eq("ovf_valid", {63'd0, MSG_VALID}, 64'd0);
        check_eq("ovf_flag", {63'd0, OVERFLOW}, 64'd1);
        check_eq("ovf_used", 64'(dut.used), 64'd0);
`ifdef ULPB_RX_FIFO_DROP_CNT_EN
        check_eq("drop_cnt", {56'd0, DROP_CNT}, 64'd1);
`else
        check_eq("drop_cnt", {56'd0, DROP_CNT}, 64'd0);
`endif

        // Streaming: seven committed words, then continuous pops with new arrivals
        MSG_READY = 1'b0;
        for (int i = 0; i < 7; i++) send_msg(1, 1'b1);
        check_eq("preload_used", 64'(dut.used), 64'd7);
        MSG_READY = 1'b1;
        for (int i = 0; i < 100; i++) send_msg(1, 1'b1);
        drain();

        // Reset in the middle of a four-word message while a handshake is open
        MSG_READY = 1'b0;
        send_msg(1, 1'b1);
        send_word(8'h61, 32'h6161_6161, 1'b1);
        send_word(8'h62, 32'h6262_6262, 1'b1);
        RX_ADDR = 8'h63; RX_DATA = 32'h6363_6363; RX_PEND = 1'b1; RX_REQ = 1'b1;
        wait_ack(1'b1, e);
        check_eq("pre_rst_valid", {63'd0, MSG_VALID}, 64'd1);
        #1;
        RESET = 1'b1;
        #1;
        sb.delete();
        check_eq("mid_rst_ack", {63'd0, RX_ACK}, 64'd0);
        check_eq("mid_rst_valid", {63'd0, MSG_VALID}, 64'd0);
        check_eq("mid_rst_head", {23'd0, MSG_ADDR, MSG_DATA, MSG_LAST}, 64'd0);
        check_eq("mid_rst_ovf", {56'd0, DROP_CNT, 7'd0, OVERFLOW}, 64'd0);
        RX_REQ = 1'b0;
        step();
        RESET = 1'b0;
        step();
        send_msg(2, 1'b1);
        check_eq("post_rst_valid", {63'd0, MSG_VALID}, 64'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
